// File: rtl/mem_stage_unit.sv
// mem_stage_unit -- MEM stage of the 5-stage pipeline.
// Issues loads/stores to a variable-latency data memory over a req/ack
// handshake, stalls upstream while an access is outstanding, aborts an
// access that waits TIMEOUT cycles, and fills the MEM/WB register.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned memory ops retire
// immediately with busErrW instead of being issued as word accesses).
module mem_stage_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regWriteM,
  input  logic        memToRegM,
  input  logic        memWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] writeDataM,
  input  logic [4:0]  writeRegM,
  output logic        stallM,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic        memAck,
  input  logic [31:0] memRData,
  output logic        regWriteW,
  output logic        memToRegW,
  output logic [31:0] readDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  writeRegW,
  output logic        busErrW
);

  // Counter is wide enough to hold TIMEOUT-1; at least one bit.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  // Contents of the MEM/WB register.
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  write_reg;
    logic        bus_err;
  } wb_t;

  // An all-zero MEM/WB entry: no register write, no error.
  function automatic wb_t wb_bubble();
    wb_t w;
    w.reg_write  = 1'b0;
    w.mem_to_reg = 1'b0;
    w.read_data  = 32'h0000_0000;
    w.alu_out    = 32'h0000_0000;
    w.write_reg  = 5'd0;
    w.bus_err    = 1'b0;
    return w;
  endfunction

  // Normal retirement of the instruction currently held in EX/MEM.
  function automatic wb_t wb_retire(input logic        rw,
                                    input logic        mtr,
                                    input logic [31:0] rdata,
                                    input logic [31:0] alu,
                                    input logic [4:0]  wreg);
    wb_t w;
    w.reg_write  = rw;
    w.mem_to_reg = mtr;
    w.read_data  = rdata;
    w.alu_out    = alu;
    w.write_reg  = wreg;
    w.bus_err    = 1'b0;
    return w;
  endfunction

  // Faulted retirement: keep address/destination for diagnosis, suppress
  // the register write and flag the bus error.
  function automatic wb_t wb_fault(input logic [31:0] alu,
                                   input logic [4:0]  wreg);
    wb_t w;
    w.reg_write  = 1'b0;
    w.mem_to_reg = 1'b0;
    w.read_data  = 32'h0000_0000;
    w.alu_out    = alu;
    w.write_reg  = wreg;
    w.bus_err    = 1'b1;
    return w;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  wb_t             wb_q, wb_d;

  logic            mem_op_s;
  logic            misalign_s;
  logic            timeout_s;
  logic [31:0]     word_addr_s;

  // Decode the incoming instruction and the access-timeout condition.
  always_comb begin
    mem_op_s    = memToRegM | memWriteM;
    word_addr_s = {ALUOutM[31:2], 2'b00};
`ifdef MEM_ALIGN_CHECK_EN
    misalign_s  = (ALUOutM[1:0] != 2'b00);
`else
    misalign_s  = 1'b0;
`endif
    if (state_q == S_ACCESS) begin
      timeout_s = (cnt_q == CNT_LAST);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next-state, request and MEM/WB computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_d        = wb_bubble();

    case (state_q)
      S_IDLE: begin
        if (mem_op_s && !misalign_s) begin
          // Launch the access; WB receives a bubble while we wait.
          state_d     = S_ACCESS;
          cnt_d       = {CW{1'b0}};
          mem_req_d   = 1'b1;
          mem_we_d    = memWriteM;
          mem_addr_d  = word_addr_s;
          mem_wdata_d = writeDataM;
          wb_d        = wb_bubble();
        end else if (mem_op_s) begin
          // Misaligned op (only reachable with the alignment check).
          wb_d = wb_fault(ALUOutM, writeRegM);
        end else begin
          // Pass-through of a non-memory instruction; stray ack ignored.
          wb_d = wb_retire(regWriteM, memToRegM, 32'h0000_0000,
                           ALUOutM, writeRegM);
        end
      end

      S_ACCESS: begin
        if (memAck) begin
          // Completion wins over a simultaneous timeout.
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wb_d      = wb_retire(regWriteM, memToRegM,
                                mem_we_q ? 32'h0000_0000 : memRData,
                                ALUOutM, writeRegM);
        end else if (timeout_s) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wb_d      = wb_fault(ALUOutM, writeRegM);
        end else begin
          // Keep waiting; counter saturates rather than wrapping.
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            cnt_d = cnt_q;
          end
          wb_d = wb_bubble();
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = {CW{1'b0}};
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        wb_d      = wb_bubble();
      end
    endcase
  end

  // Upstream freeze: hold while launching or waiting on an access.
  always_comb begin
    case (state_q)
      S_IDLE: begin
        stallM = mem_op_s & ~misalign_s;
      end
      S_ACCESS: begin
        stallM = ~memAck & ~timeout_s;
      end
      default: begin
        stallM = 1'b0;
      end
    endcase
  end

  // State, request and MEM/WB registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      wb_q        <= wb_bubble();
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_q        <= wb_d;
    end
  end

  assign memReq    = mem_req_q;
  assign memWe     = mem_we_q;
  assign memAddr   = mem_addr_q;
  assign memWData  = mem_wdata_q;
  assign regWriteW = wb_q.reg_write;
  assign memToRegW = wb_q.mem_to_reg;
  assign readDataW = wb_q.read_data;
  assign ALUOutW   = wb_q.alu_out;
  assign writeRegW = wb_q.write_reg;
  assign busErrW   = wb_q.bus_err;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit (TIMEOUT = 4).
// Each instruction's expected behaviour is derived at transaction level:
// number of ACCESS cycles n from the ack latency, stall for n cycles,
// n bubbles in WB, then the retired (or faulted) WB entry.
module tb_mem_stage_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        regWriteM, memToRegM, memWriteM;
  logic [31:0] ALUOutM, writeDataM;
  logic [4:0]  writeRegM;
  logic        stallM, memReq, memWe;
  logic [31:0] memAddr, memWData;
  logic        memAck;
  logic [31:0] memRData;
  logic        regWriteW, memToRegW;
  logic [31:0] readDataW, ALUOutW;
  logic [4:0]  writeRegW;
  logic        busErrW;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM),
    .ALUOutM(ALUOutM), .writeDataM(writeDataM), .writeRegM(writeRegM),
    .stallM(stallM), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWData(memWData),
    .memAck(memAck), .memRData(memRData),
    .regWriteW(regWriteW), .memToRegW(memToRegW),
    .readDataW(readDataW), .ALUOutW(ALUOutW),
    .writeRegW(writeRegW), .busErrW(busErrW)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic rw, input logic mtr,
                        input logic [31:0] rd, input logic [31:0] alu,
                        input logic [4:0] wr, input logic be);
    chk({tag, ".regWriteW"}, {31'd0, regWriteW}, {31'd0, rw});
    chk({tag, ".memToRegW"}, {31'd0, memToRegW}, {31'd0, mtr});
    chk({tag, ".readDataW"}, readDataW, rd);
    chk({tag, ".ALUOutW"},   ALUOutW,   alu);
    chk({tag, ".writeRegW"}, {27'd0, writeRegW}, {27'd0, wr});
    chk({tag, ".busErrW"},   {31'd0, busErrW},   {31'd0, be});
  endtask

  // kind: 0 = R-type, 1 = load, 2 = store. lat: ack on ACCESS cycle lat
  // (lat > TO means the memory never answers). rdv: load data on the ack.
  task automatic run_instr(input string tag, input int kind,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] wr, input logic rw,
                           input int lat, input logic [31:0] rdv);
    logic misal;
    int   n;
    logic acked;
    regWriteM  = rw;
    memToRegM  = (kind == 1);
    memWriteM  = (kind == 2);
    ALUOutM    = alu;
    writeDataM = wd;
    writeRegM  = wr;
`ifdef MEM_ALIGN_CHECK_EN
    misal = (alu[1:0] != 2'b00);
`else
    misal = 1'b0;
`endif
    if (kind == 0 || misal) begin
      memAck   = 1'($urandom_range(0, 1));
      memRData = $urandom;
      @(negedge clk);
      chk({tag, ".stall"},  {31'd0, stallM}, 32'd0);
      chk({tag, ".memReq"}, {31'd0, memReq}, 32'd0);
      tick();
      memAck = 1'b0;
      if (misal) chk_wb(tag, 1'b0, 1'b0, 32'd0, alu, wr, 1'b1);
      else       chk_wb(tag, rw, 1'b0, 32'd0, alu, wr, 1'b0);
    end else begin
      acked = (lat >= 1 && lat <= TO);
      n     = acked ? lat : TO;
      for (int c = 0; c <= n; c++) begin
        if (c == 0)             memAck = 1'($urandom_range(0, 1));
        else if (acked && c == lat) memAck = 1'b1;
        else                    memAck = 1'b0;
        memRData = (c == lat) ? rdv : $urandom;
        @(negedge clk);
        chk({tag, ".stall"},  {31'd0, stallM}, {31'd0, (c < n)});
        chk({tag, ".memReq"}, {31'd0, memReq}, {31'd0, (c >= 1)});
        if (c >= 1) begin
          chk({tag, ".memAddr"},  memAddr, {alu[31:2], 2'b00});
          chk({tag, ".memWe"},    {31'd0, memWe}, {31'd0, (kind == 2)});
          chk({tag, ".memWData"}, memWData, wd);
          chk({tag, ".bubble.regWriteW"}, {31'd0, regWriteW}, 32'd0);
          chk({tag, ".bubble.ALUOutW"},   ALUOutW, 32'd0);
          chk({tag, ".bubble.busErrW"},   {31'd0, busErrW}, 32'd0);
        end
        tick();
      end
      memAck = 1'b0;
      chk({tag, ".memReq_drop"}, {31'd0, memReq}, 32'd0);
      if (acked) chk_wb(tag, rw, (kind == 1), (kind == 1) ? rdv : 32'd0, alu, wr, 1'b0);
      else       chk_wb(tag, 1'b0, 1'b0, 32'd0, alu, wr, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    regWriteM = 1'b0; memToRegM = 1'b0; memWriteM = 1'b0;
    ALUOutM = 32'd0; writeDataM = 32'd0; writeRegM = 5'd0;
    memAck = 1'b0; memRData = 32'd0;
    tick();
    tick();
    @(negedge clk);
    chk("reset.memReq", {31'd0, memReq}, 32'd0);
    chk("reset.memAddr", memAddr, 32'd0);
    chk("reset.stall", {31'd0, stallM}, 32'd0);
    chk_wb("reset", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    rst = 1'b0;
    tick();

    // Directed scenarios.
    run_instr("rtype",   0, 32'h0000_0042, 32'h0, 5'd5, 1'b1, 0, 32'h0);
    run_instr("load1",   1, 32'h0000_0100, 32'h1111_2222, 5'd7, 1'b1, 1, 32'hDEAD_BEEF);
    run_instr("store3",  2, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 1'b0, 3, 32'h0);
    run_instr("tmo",     1, 32'h0000_0400, 32'h0, 5'd9, 1'b1, TO + 5, 32'h0);
    run_instr("post_tmo", 0, 32'h0000_0077, 32'h0, 5'd3, 1'b1, 0, 32'h0);
    run_instr("ack_at_tmo", 1, 32'h0000_0500, 32'h0, 5'd11, 1'b1, TO, 32'h1234_5678);
    run_instr("misalign", 1, 32'h0000_0102, 32'h0, 5'd12, 1'b1, 1, 32'hA5A5_5A5A);

    // Reset while an access is outstanding, then a late ack.
    regWriteM = 1'b1; memToRegM = 1'b0; memWriteM = 1'b1;
    ALUOutM = 32'h0000_0300; writeDataM = 32'h5555_AAAA; writeRegM = 5'd4;
    tick();
    tick();
    @(negedge clk);
    chk("rst_acc.memReq_before", {31'd0, memReq}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_acc.memReq", {31'd0, memReq}, 32'd0);
    chk("rst_acc.memWe", {31'd0, memWe}, 32'd0);
    chk("rst_acc.memAddr", memAddr, 32'd0);
    chk("rst_acc.memWData", memWData, 32'd0);
    chk_wb("rst_acc", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    rst = 1'b0;
    regWriteM = 1'b0; memWriteM = 1'b0; ALUOutM = 32'd0;
    writeDataM = 32'd0; writeRegM = 5'd0;
    memAck = 1'b1; memRData = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_ack.stall", {31'd0, stallM}, 32'd0);
    tick();
    memAck = 1'b0;
    chk("late_ack.memReq", {31'd0, memReq}, 32'd0);
    chk_wb("late_ack", 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);

    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      int          k;
      int          l;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      l = $urandom_range(1, TO + 2);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_instr("rand", k, a, $urandom, 5'($urandom), 1'($urandom), l, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound on simulation time in case of a hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/mem_stage_unit.md
# mem_stage_unit

Memory stage of the 5-stage pipeline: consumes the EX/MEM pipeline register outputs and performs loads/stores against an external variable-latency data memory over a req/ack handshake. Results go into the MEM/WB register (writeback side). Stalls the upstream pipeline while an access is outstanding, and aborts accesses that exceed a timeout.

## Interface
Parameters:
- `TIMEOUT`, 16: max cycles in ACCESS waiting for `memAck` before abort; legal range 2..255.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `regWriteM`, `memToRegM`, `memWriteM`  in  1 each  control from EX/MEM register.
- `ALUOutM`  in  32  address (mem op) or ALU result.
- `writeDataM`  in  32  store data.
- `writeRegM`  in  5  destination register.
- `stallM`  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM when high.
- `memReq`  out  1  registered access request.
- `memWe`  out  1  registered; 1 = store.
- `memAddr`  out  32  registered address.
- `memWData`  out  32  registered store data.
- `memAck`  in  1  memory completion, one-cycle pulse.
- `memRData`  in  32  load data, valid with `memAck`.
- `regWriteW`, `memToRegW`  out  1 each  MEM/WB control.
- `readDataW`, `ALUOutW`  out  32 each  MEM/WB data.
- `writeRegW`  out  5  MEM/WB destination.
- `busErrW`  out  1  one-cycle flag on an aborted instruction.

## Operation
- memOp = `memToRegM | memWriteM`. FSM states: IDLE, ACCESS.
- IDLE, !memOp: W regs capture M inputs (`readDataW`=0, `busErrW`=0); stay IDLE.
- IDLE, memOp: latch `memReq`=1, `memWe`=`memWriteM`, `memAddr`, `memWData`; clear timeout counter; go to ACCESS. W regs load a bubble (all W outputs 0).
- ACCESS, `memAck`=1: W regs capture M inputs, `readDataW`=`memRData` (0 for stores), `busErrW`=0. `memReq`/`memWe` drop to 0; return to IDLE.
- ACCESS, !`memAck`, counter = `TIMEOUT`-1: abort. W regs capture `writeRegM`/`ALUOutM`, with `regWriteW`=0, `memToRegW`=0, `busErrW`=1. `memReq` drops; return to IDLE.
- ACCESS, otherwise: counter+1. W regs load a bubble.
- `stallM` = (IDLE & memOp) | (ACCESS & !`memAck` & !timeout). It is low on the completing/aborting cycle so upstream advances on that edge.
- `memAck` in IDLE is ignored.
- Counter width is $clog2(TIMEOUT); it saturates and never wraps.
- `memAck` and timeout on the same cycle: ack wins, so the access completes normally.
- Reset: state IDLE, counter 0, all outputs 0 including `memReq`, `memWe`, `memAddr`, `memWData`, and all W outputs. Reset in ACCESS drops `memReq` on the next edge; a late `memAck` is then ignored.

## Timing
- Non-memory instruction: 1-cycle latency M→W, no stall.
- Memory op with ack in first ACCESS cycle: 2 cycles in MEM, 1 stall cycle; W valid at the 2nd edge after entry.
- Ack on ACCESS cycle k (k≥1): k stall cycles plus the completion cycle; k bubbles are inserted into WB.
- Timeout: instruction retires with `busErrW` after exactly `TIMEOUT` ACCESS cycles.
- `memAddr`/`memWData`/`memWe` are stable for the whole time `memReq` is high.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: in IDLE, a memOp with `ALUOutM[1:0]`≠0 issues no request and does not stall. It retires next edge with `regWriteW`=0, `memToRegW`=0, `busErrW`=1.
- Not defined: no check; `memAddr` = {`ALUOutM[31:2]`, 2'b00}, and misaligned accesses proceed as word accesses.

## Test plan
- R-type, `regWriteM`=1, `ALUOutM`=0x0000_0042, `writeRegM`=5 -> next edge `regWriteW`=1, `ALUOutW`=0x42, `writeRegW`=5, `stallM` never high.
- Load from 0x100, `memAck` in 1st ACCESS cycle with `memRData`=0xDEADBEEF -> `stallM` high 1 cycle, `readDataW`=0xDEADBEEF, `memToRegW`=1 at the 2nd edge, 1 bubble in WB.
- Store 0xCAFEF00D to 0x200, ack after 3 ACCESS cycles -> `memWe`=1, `memAddr`=0x200 stable while `memReq` high, 3 stall cycles, `regWriteW`=0.
- Load with no ack, `TIMEOUT`=4 -> `memReq` high 4 cycles, then `busErrW`=1 for 1 cycle, `regWriteW`=0, `stallM` low; a later stray `memAck` changes nothing.
- `rst` asserted in ACCESS, then ack 1 cycle later -> all outputs 0 after the reset edge, state IDLE, ack ignored.
- With `MEM_ALIGN_CHECK_EN`: load from 0x102 -> no `memReq`, no stall, `busErrW`=1 next edge. Without it: `memAddr`=0x100.
